// File: rtl/dp_pkg.sv
// dp_pkg: opcodes, ALU operation codes, register-field width and the
// control bundle carried down the datapath_fwd pipeline.
package dp_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_NOR   = 3'd5,
        ALU_SLT   = 3'd6,
        ALU_PASSB = 3'd7
    } aluop_e;

    typedef struct packed {
        aluop_e              aluop;
        logic [REG_AW-1:0]   dest;
        logic                wen;
        logic                valid;
    } ctrl_t;

    // True for an implemented, writable register (not r0, below nreg).
    function automatic logic reg_ok(input logic [REG_AW-1:0] a,
                                    input int nreg);
        return (a != '0) && (int'(a) < nreg);
    endfunction

endpackage

// File: rtl/regfile_p.sv
// regfile_p: NREG x DSIZE register file, 2 async read ports, 1 write port.
// r0 and addresses >= NREG read as zero; writes to them are dropped.
module regfile_p
    import dp_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int NREG  = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DSIZE-1:0]  rdata1_o,
    output logic [DSIZE-1:0]  rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DSIZE-1:0]  wdata_i
);

    logic [DSIZE-1:0] regs_q [1:NREG-1];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 1; i < NREG; i++)
                if (waddr_i == REG_AW'(i))
                    regs_q[i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        for (int i = 1; i < NREG; i++) begin
            if (raddr1_i == REG_AW'(i))
                rdata1_o = regs_q[i];
            if (raddr2_i == REG_AW'(i))
                rdata2_o = regs_q[i];
        end
    end

endmodule

// File: rtl/datapath_fwd.sv
// datapath_fwd: 3-stage ID/EX/WB integer datapath with EX->ID, WB->ID forwarding.
// Ports: clk, rst (async low), inst/inst_valid in; WB_aluout/waddr/wen/valid out.
module datapath_fwd
    import dp_pkg::*;
#(
    parameter int DSIZE      = 32,
    parameter int NREG       = 32,
    parameter int IMM_SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    output logic [DSIZE-1:0]  WB_aluout,
    output logic [REG_AW-1:0] WB_waddr,
    output logic              WB_wen,
    output logic              WB_valid
);

    // ID stage
    logic [31:0] id_inst_q;
    logic        id_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            id_inst_q  <= inst;
            id_valid_q <= inst_valid;
        end
    end

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [15:0]       imm;
    logic [DSIZE-1:0]  imm_ext;

    assign opcode = id_inst_q[31:26];
    assign rs1    = id_inst_q[25:21];
    assign rs2    = id_inst_q[20:16];
    assign imm    = id_inst_q[15:0];
    assign imm_ext = (IMM_SIGNED != 0) ? DSIZE'($signed(imm))
                                       : DSIZE'(imm);

    ctrl_t ex_ctrl_d;
    logic  id_legal;
    logic  id_use_imm;

    always_comb begin
        ex_ctrl_d       = '0;
        ex_ctrl_d.valid = id_valid_q;
        ex_ctrl_d.dest  = id_inst_q[20:16];
        id_legal        = 1'b1;
        id_use_imm      = 1'b1;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                ex_ctrl_d.aluop = aluop_e'(id_inst_q[2:0]);
                ex_ctrl_d.dest  = id_inst_q[15:11];
                id_use_imm      = 1'b0;
            end
            (opcode == OP_ADDI): ex_ctrl_d.aluop = ALU_ADD;
            (opcode == OP_ANDI): ex_ctrl_d.aluop = ALU_AND;
            (opcode == OP_ORI):  ex_ctrl_d.aluop = ALU_OR;
            (opcode == OP_XORI): ex_ctrl_d.aluop = ALU_XOR;
            default:             id_legal = 1'b0;
        endcase
        // Writes to r0 or unimplemented registers are killed here so the
        // forwarding compare never matches them downstream.
        ex_ctrl_d.wen = id_valid_q & id_legal
                      & reg_ok(ex_ctrl_d.dest, NREG);
    end

    // EX / WB state
    logic [DSIZE-1:0]  ex_a_q, ex_b_q;
    ctrl_t             ex_ctrl_q;
    logic [DSIZE-1:0]  wb_aluout_q;
    logic [REG_AW-1:0] wb_waddr_q;
    logic              wb_wen_q;
    logic              wb_valid_q;

    logic [DSIZE-1:0] rf_a, rf_b;
    logic [DSIZE-1:0] fwd_a, fwd_b;
    logic [DSIZE-1:0] ex_a_d, ex_b_d;
    logic [DSIZE-1:0] alu_res;

    regfile_p #(
        .DSIZE (DSIZE),
        .NREG  (NREG)
    ) u_rf (
        .clk      (clk),
        .rst_ni   (rst),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_a),
        .rdata2_o (rf_b),
        .we_i     (wb_wen_q),
        .waddr_i  (wb_waddr_q),
        .wdata_i  (wb_aluout_q)
    );

    // Youngest producer wins: EX result, then WB result, then the file.
    always_comb begin
        fwd_a = rf_a;
        if (reg_ok(rs1, NREG) && ex_ctrl_q.wen && ex_ctrl_q.dest == rs1)
            fwd_a = alu_res;
        else if (reg_ok(rs1, NREG) && wb_wen_q && wb_waddr_q == rs1)
            fwd_a = wb_aluout_q;

        fwd_b = rf_b;
        if (reg_ok(rs2, NREG) && ex_ctrl_q.wen && ex_ctrl_q.dest == rs2)
            fwd_b = alu_res;
        else if (reg_ok(rs2, NREG) && wb_wen_q && wb_waddr_q == rs2)
            fwd_b = wb_aluout_q;
    end

    assign ex_a_d = fwd_a;
    assign ex_b_d = id_use_imm ? imm_ext : fwd_b;

    always_comb begin
        alu_res = '0;
        unique case (ex_ctrl_q.aluop)
            ALU_ADD:   alu_res = ex_a_q + ex_b_q;
            ALU_SUB:   alu_res = ex_a_q - ex_b_q;
            ALU_AND:   alu_res = ex_a_q & ex_b_q;
            ALU_OR:    alu_res = ex_a_q | ex_b_q;
            ALU_XOR:   alu_res = ex_a_q ^ ex_b_q;
            ALU_NOR:   alu_res = ~(ex_a_q | ex_b_q);
            ALU_SLT:   alu_res = DSIZE'($signed(ex_a_q) < $signed(ex_b_q));
            ALU_PASSB: alu_res = ex_b_q;
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_ctrl_q   <= '0;
            wb_aluout_q <= '0;
            wb_waddr_q  <= '0;
            wb_wen_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else begin
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_ctrl_q   <= ex_ctrl_d;
            wb_aluout_q <= alu_res;
            wb_waddr_q  <= ex_ctrl_q.dest;
            wb_wen_q    <= ex_ctrl_q.wen;
            wb_valid_q  <= ex_ctrl_q.valid;
        end
    end

    assign WB_aluout = wb_aluout_q;
    assign WB_waddr  = wb_waddr_q;
    assign WB_wen    = wb_wen_q;
    assign WB_valid  = wb_valid_q;

endmodule

// File: tb/tb_datapath_fwd.sv
// tb_datapath_fwd: two datapath_fwd instances (NREG 32 zero-ext, NREG 8
// sign-ext) checked against an architectural register-file model.
`timescale 1ns/1ps
module tb_datapath_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;

    logic [31:0] d0, d1;
    logic [4:0]  a0, a1;
    logic        w0, w1, v0, v1;

    datapath_fwd #(.DSIZE(32), .NREG(32), .IMM_SIGNED(0)) dut0 (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .WB_aluout(d0), .WB_waddr(a0), .WB_wen(w0), .WB_valid(v0));

    datapath_fwd #(.DSIZE(32), .NREG(8), .IMM_SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .WB_aluout(d1), .WB_waddr(a1), .WB_wen(w1), .WB_valid(v1));

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          w;
        logic [4:0]  a;
        logic [31:0] d;
        bit          cd;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        e0, e1;
    logic [31:0] mr [2][32];
    int          nreg_m [2] = '{32, 8};
    bit          sgn_m [2] = '{1'b0, 1'b1};
    int          ncmp = 0;
    int          nerr = 0;

    function automatic logic [31:0] rt(input int op, input int rd,
                                       input int rs1, input int rs2);
        return {6'h00, 5'(rs1), 5'(rs2), 5'(rd), 8'h00, 3'(op)};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] opc, input int rd,
                                       input int rs, input logic [15:0] imm);
        return {opc, 5'(rs), 5'(rd), imm};
    endfunction

    function automatic logic [31:0] rdm(input int k, input logic [4:0] r);
        if (r == 5'd0 || int'(r) >= nreg_m[k]) return 32'h0;
        return mr[k][r];
    endfunction

    // Sequential ISA semantics: the architectural state is updated at issue.
    task automatic model(input int k, input logic [31:0] i, input bit v,
                         output exp_t e);
        logic [31:0] a, b, imm, r;
        int op, dst;
        bit ok;
        a   = rdm(k, i[25:21]);
        b   = rdm(k, i[20:16]);
        imm = sgn_m[k] ? {{16{i[15]}}, i[15:0]} : {16'h0, i[15:0]};
        ok  = 1'b1;
        op  = 0;
        dst = int'(i[20:16]);
        case (i[31:26])
            6'h00: begin op = int'(i[2:0]); dst = int'(i[15:11]); end
            6'h08: begin op = 0; b = imm; end
            6'h0C: begin op = 2; b = imm; end
            6'h0D: begin op = 3; b = imm; end
            6'h0E: begin op = 4; b = imm; end
            default: ok = 1'b0;
        endcase
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a | b);
            6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = b;
        endcase
        e.v  = v;
        e.cd = v && ok;
        e.w  = v && ok && dst != 0 && dst < nreg_m[k];
        e.a  = 5'(dst);
        e.d  = r;
        if (e.w) mr[k][dst] = r;
    endtask

    task automatic do_reset();
        exp_t z;
        z = '{v: 1'b0, w: 1'b0, a: 5'd0, d: 32'd0, cd: 1'b1};
        rst = 1'b0;
        inst = 32'h0;
        inst_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++)
                mr[k][r] = 32'h0;
        q0.delete();
        q1.delete();
        repeat (2) begin
            q0.push_back(z);
            q1.push_back(z);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Drive one instruction, advance one edge, expose the WB-stage expectation.
    task automatic step(input logic [31:0] i, input bit v);
        exp_t e;
        inst = i;
        inst_valid = v;
        model(0, i, v, e);
        q0.push_back(e);
        model(1, i, v, e);
        q1.push_back(e);
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        ncmp++;
        if ({v0, w0, a0, d0, v1, w1, a1, d1} !== '0) begin
            nerr++;
            $display("FAIL reset_hold: got d0=%h a0=%0d d1=%h v0=%b v1=%b, want all 0",
                     d0, a0, d1, v0, v1);
        end
        do_reset();
        ncmp++;
        if ({v0, w0, a0, d0, v1, w1, a1, d1} !== '0) begin
            nerr++;
            $display("FAIL reset_release: got d0=%h d1=%h v0=%b w0=%b, want all 0",
                     d0, d1, v0, w0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [5];
        bit          vl [5];
        logic [31:0] want_d [3];
        logic [4:0]  want_a [3];
        prog = '{it(6'h08, 1, 0, 16'd5), it(6'h08, 2, 0, 16'd7),
                 rt(0, 3, 1, 2), 32'h0, 32'h0};
        vl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        want_d = '{32'd5, 32'd7, 32'd12};
        want_a = '{5'd1, 5'd2, 5'd3};
        for (int j = 0; j < 5; j++) begin
            step(prog[j], vl[j]);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL b2b[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL b2b[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
            if (j >= 2) begin
                ncmp++;
                if (d0 !== want_d[j-2] || a0 !== want_a[j-2] || w0 !== 1'b1) begin
                    nerr++;
                    $display("FAIL b2b_const[%0d]: got d=%0d a=%0d w=%b, want d=%0d a=%0d w=1",
                             j, d0, a0, w0, want_d[j-2], want_a[j-2]);
                end
            end
        end
    endtask

    task automatic test_imm_ext();
        logic [31:0] prog [3];
        prog = '{it(6'h08, 1, 0, 16'hFFFF), 32'h0, 32'h0};
        for (int j = 0; j < 3; j++) begin
            step(prog[j], j == 0);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL imm[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL imm[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
        end
        ncmp++;
        if (d0 !== 32'h0000FFFF || d1 !== 32'hFFFFFFFF) begin
            nerr++;
            $display("FAIL imm_const: got zext=%h sext=%h, want 0000ffff ffffffff", d0, d1);
        end
    endtask

    task automatic test_fwd_bubble();
        logic [31:0] prog [6];
        bit          vl [6];
        prog = '{it(6'h08, 4, 0, 16'd9), 32'h0, rt(1, 5, 4, 4),
                 rt(6, 6, 4, 1), 32'h0, 32'h0};
        vl = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int j = 0; j < 6; j++) begin
            step(prog[j], vl[j]);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL fwd[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL fwd[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
            if (j == 4) begin
                ncmp++;
                if (d0 !== 32'd0 || d1 !== 32'd0 || a0 !== 5'd5) begin
                    nerr++;
                    $display("FAIL sub_wbfwd: got d0=%h d1=%h a=%0d, want 0 0 5", d0, d1, a0);
                end
            end
            if (j == 5) begin
                ncmp++;
                if (d1 !== 32'd0 || d0 !== 32'd1) begin
                    nerr++;
                    $display("FAIL slt_signed: got sext=%h zext=%h, want 0 1", d1, d0);
                end
            end
        end
    endtask

    task automatic test_r0_range();
        logic [31:0] prog [5];
        bit          vl [5];
        prog = '{it(6'h08, 0, 0, 16'd3), rt(3, 7, 0, 0),
                 it(6'h08, 9, 0, 16'd1), 32'h0, 32'h0};
        vl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int j = 0; j < 5; j++) begin
            step(prog[j], vl[j]);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL r0rng[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL r0rng[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
            if (j == 2) begin
                ncmp++;
                if (w0 !== 1'b0 || w1 !== 1'b0 || v0 !== 1'b1) begin
                    nerr++;
                    $display("FAIL r0_write: got w0=%b w1=%b v0=%b, want 0 0 1", w0, w1, v0);
                end
            end
            if (j == 3) begin
                ncmp++;
                if (d0 !== 32'd0 || d1 !== 32'd0) begin
                    nerr++;
                    $display("FAIL r0_read: got d0=%h d1=%h, want 0 0", d0, d1);
                end
            end
            if (j == 4) begin
                ncmp++;
                if (w1 !== 1'b0 || w0 !== 1'b1) begin
                    nerr++;
                    $display("FAIL nreg_write: got w1=%b w0=%b, want 0 1", w1, w0);
                end
            end
        end
    endtask

    task automatic test_nop();
        logic [31:0] prog [5];
        bit          vl [5];
        prog = '{{6'h3F, 5'd0, 5'd2, 16'h1234}, it(6'h08, 2, 0, 16'h55),
                 rt(3, 7, 2, 0), 32'h0, 32'h0};
        vl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int j = 0; j < 5; j++) begin
            step(prog[j], vl[j]);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL nop[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL nop[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
            if (j == 2) begin
                ncmp++;
                if (v0 !== 1'b1 || w0 !== 1'b0) begin
                    nerr++;
                    $display("FAIL undef_op: got v=%b w=%b, want v=1 w=0", v0, w0);
                end
            end
            if (j == 3) begin
                ncmp++;
                if (v0 !== 1'b0 || w0 !== 1'b0) begin
                    nerr++;
                    $display("FAIL bubble: got v=%b w=%b, want v=0 w=0", v0, w0);
                end
            end
            if (j == 4) begin
                ncmp++;
                if (d0 !== 32'd7 || d1 !== 32'd7) begin
                    nerr++;
                    $display("FAIL nop_noreg: got r2 d0=%h d1=%h, want 7 7", d0, d1);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] prog [10];
        bit          vl [10];
        step(it(6'h08, 1, 0, 16'h11), 1'b1);
        step(it(6'h08, 2, 0, 16'h22), 1'b1);
        step(it(6'h08, 3, 0, 16'h33), 1'b1);
        #3 rst = 1'b0;
        #1;
        ncmp++;
        if ({v0, w0, a0, d0, v1, w1, a1, d1} !== '0) begin
            nerr++;
            $display("FAIL inflight_rst: got d0=%h a0=%0d w0=%b v0=%b, want all 0",
                     d0, a0, w0, v0);
        end
        do_reset();
        for (int r = 1; r < 8; r++) begin
            prog[r-1] = rt(3, r, r, 0);
            vl[r-1] = 1'b1;
        end
        prog[7] = it(6'h08, 1, 0, 16'h42);
        prog[8] = 32'h0;
        prog[9] = 32'h0;
        vl[7] = 1'b1;
        vl[8] = 1'b0;
        vl[9] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(prog[j], vl[j]);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL postrst[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL postrst[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
            if (j >= 2 && j <= 8) begin
                ncmp++;
                if (d0 !== 32'd0 || d1 !== 32'd0 || w0 !== 1'b1) begin
                    nerr++;
                    $display("FAIL rf_cleared[%0d]: got d0=%h d1=%h w0=%b, want 0 0 1",
                             j, d0, d1, w0);
                end
            end
            if (j == 9) begin
                ncmp++;
                if (d0 !== 32'h42 || a0 !== 5'd1) begin
                    nerr++;
                    $display("FAIL first_after_rst: got d=%h a=%0d, want 42 1", d0, a0);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] i;
        logic [5:0]  undef [4];
        logic [5:0]  iops [4];
        int          sel;
        bit          v;
        undef = '{6'h3F, 6'h01, 6'h09, 6'h20};
        iops  = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
        for (int j = 0; j < 400; j++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)
                i = rt($urandom_range(0, 7), $urandom_range(0, 11),
                       $urandom_range(0, 11), $urandom_range(0, 11));
            else if (sel < 9)
                i = it(iops[$urandom_range(0, 3)], $urandom_range(0, 11),
                       $urandom_range(0, 11), 16'($urandom));
            else
                i = {undef[$urandom_range(0, 3)], 26'($urandom)};
            v = ($urandom_range(0, 9) != 0);
            step(i, v);
            ncmp++;
            if (v0 !== e0.v || w0 !== e0.w || (e0.cd && (a0 !== e0.a || d0 !== e0.d))) begin
                nerr++;
                $display("FAIL rand[%0d] dut0: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v0, w0, a0, d0, e0.v, e0.w, e0.a, e0.d);
            end
            ncmp++;
            if (v1 !== e1.v || w1 !== e1.w || (e1.cd && (a1 !== e1.a || d1 !== e1.d))) begin
                nerr++;
                $display("FAIL rand[%0d] dut1: got v=%b w=%b a=%0d d=%h, want v=%b w=%b a=%0d d=%h",
                         j, v1, w1, a1, d1, e1.v, e1.w, e1.a, e1.d);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        inst = 32'h0;
        inst_valid = 1'b0;
        test_reset();
        test_back_to_back();
        test_imm_ext();
        test_fwd_bubble();
        test_r0_range();
        test_nop();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
